cpu_ram_responder: RTL and testbench

Memory-side responder for the 16-bit accumulator CPU's RAM port. It holds the unified instruction/data memory and answers the CPU's address, write-enable and write-data signals with one-cycle-latency read data. It also provides a valid/ready loader port that fills memory while the CPU is held in reset, then releases the CPU to run from address 0. It sits between the CPU and the board-level program loader or testbench.

---
 rtl/cpu_ram_responder_if.sv | 39 +++
 rtl/cpu_ram_responder.sv | 127 ++++++++++++
 tb/tb_cpu_ram_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ram_responder_if.sv
// rtl/cpu_ram_responder_if.sv - CPU RAM port and loader port bundle (io_out present with MMIO_OUT_EN)
interface cpu_ram_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr_toRAM;
  logic [DATA_W-1:0] data_toRAM;
  logic              wrEn;
  logic [DATA_W-1:0] data_fromRAM;
  logic              cpu_rst;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              ld_start;
  logic [ADDR_W:0]   ld_count;
`ifdef MMIO_OUT_EN
  logic [DATA_W-1:0] io_out;

  modport slave (
    input  addr_toRAM, data_toRAM, wrEn, ld_valid, ld_addr, ld_data, ld_done, ld_start,
    output data_fromRAM, cpu_rst, ld_ready, ld_count, io_out
  );
  modport master (
    output addr_toRAM, data_toRAM, wrEn, ld_valid, ld_addr, ld_data, ld_done, ld_start,
    input  data_fromRAM, cpu_rst, ld_ready, ld_count, io_out
  );
`else
  modport slave (
    input  addr_toRAM, data_toRAM, wrEn, ld_valid, ld_addr, ld_data, ld_done, ld_start,
    output data_fromRAM, cpu_rst, ld_ready, ld_count
  );
  modport master (
    output addr_toRAM, data_toRAM, wrEn, ld_valid, ld_addr, ld_data, ld_done, ld_start,
    input  data_fromRAM, cpu_rst, ld_ready, ld_count
  );
`endif
endinterface

// File: rtl/cpu_ram_responder.sv
// rtl/cpu_ram_responder.sv - unified CPU RAM with loader phase; MMIO_OUT_EN adds io_out at the top address
module cpu_ram_responder #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_ram_responder_if.slave   bus
);
  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
`ifdef MMIO_OUT_EN
  localparam logic [ADDR_W-1:0] MMIO_ADDR = {ADDR_W{1'b1}};
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_req;
  logic              mem_we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              waddr_ok;
  logic              raddr_ok;

`ifdef MMIO_OUT_EN
  logic [DATA_W-1:0] io_out_q, io_out_d;
`endif

  assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
  assign raddr_ok = ({1'b0, bus.addr_toRAM} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_req  = 1'b0;
    waddr   = bus.ld_addr;
    wdata   = bus.ld_data;
`ifdef MMIO_OUT_EN
    io_out_d = io_out_q;
`endif
    if (state_q == ST_LOAD) begin
      // CPU wrEn is deliberately ignored while the CPU is held in reset
      if (bus.ld_valid) begin
        wr_req  = 1'b1;
        count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      end
      if (bus.ld_done) begin
        state_d = ST_RUN;
      end
    end else begin
      if (bus.wrEn) begin
        waddr  = bus.addr_toRAM;
        wdata  = bus.data_toRAM;
        wr_req = 1'b1;
`ifdef MMIO_OUT_EN
        if (bus.addr_toRAM == MMIO_ADDR) begin
          wr_req   = 1'b0;
          io_out_d = bus.data_toRAM;
        end
`endif
      end
      if (bus.ld_start) begin
        state_d = ST_LOAD;
        count_d = '0;
      end
    end

    mem_we = wr_req && waddr_ok;

    // Write-first: a same-cycle write to the read address bypasses the array
    if (mem_we && (waddr == bus.addr_toRAM)) begin
      rdata_d = wdata;
    end else if (raddr_ok) begin
      rdata_d = mem[bus.addr_toRAM[IDX_W-1:0]];
    end else begin
      rdata_d = '0;
    end
`ifdef MMIO_OUT_EN
    if (bus.addr_toRAM == MMIO_ADDR) begin
      rdata_d = io_out_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MMIO_OUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_out_q <= '0;
    end else begin
      io_out_q <= io_out_d;
    end
  end

  assign bus.io_out = io_out_q;
`endif

  // Memory contents survive reset so a reloaded or reset CPU sees the old image
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign bus.data_fromRAM = rdata_q;
  assign bus.cpu_rst      = (state_q == ST_LOAD);
  assign bus.ld_ready     = (state_q == ST_LOAD);
  assign bus.ld_count     = count_q;
endmodule

// File: tb/tb_cpu_ram_responder.sv
// tb/tb_cpu_ram_responder.sv - directed self-checking bench for cpu_ram_responder (DEPTH=4096)
module tb_cpu_ram_responder;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cpu_ram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cpu_ram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    bus.addr_toRAM = '0;
    bus.data_toRAM = '0;
    bus.wrEn       = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_done    = 1'b0;
    bus.ld_start   = 1'b0;

    #12;
    chk("rst_cpu_rst",  32'(bus.cpu_rst),      32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready),     32'd1);
    chk("rst_ld_count", 32'(bus.ld_count),     32'd0);
    chk("rst_rdata",    32'(bus.data_fromRAM), 32'd0);
    rst = 1'b1;

    // Load 0x1234@0 and 0xBEEF@5, then finish the load
    bus.ld_valid = 1'b1; bus.ld_addr = 13'd0; bus.ld_data = 16'h1234;
    tick();
    chk("load_first_rdata", 32'(bus.data_fromRAM), 32'h1234);
    bus.ld_addr = 13'd5; bus.ld_data = 16'hBEEF;
    tick();
    bus.ld_valid = 1'b0; bus.ld_done = 1'b1;
    tick();
    bus.ld_done = 1'b0;
    chk("done_cpu_rst",  32'(bus.cpu_rst),  32'd0);
    chk("done_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("done_ld_count", 32'(bus.ld_count), 32'd2);

    bus.addr_toRAM = 13'd5;
    tick();
    chk("read_5", 32'(bus.data_fromRAM), 32'hBEEF);
    bus.addr_toRAM = 13'd0;
    tick();
    chk("read_0", 32'(bus.data_fromRAM), 32'h1234);

    // CPU write with write-first read-back
    bus.wrEn = 1'b1; bus.addr_toRAM = 13'd7; bus.data_toRAM = 16'hA5A5;
    tick();
    chk("wf_cpu_7", 32'(bus.data_fromRAM), 32'hA5A5);
    bus.wrEn = 1'b0;
    tick();
    chk("reread_7", 32'(bus.data_fromRAM), 32'hA5A5);

    // Back to LOAD; CPU writes must be ignored there
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("start_cpu_rst",  32'(bus.cpu_rst),  32'd1);
    chk("start_ld_count", 32'(bus.ld_count), 32'd0);
    bus.wrEn = 1'b1; bus.data_toRAM = 16'h5555;
    tick();
    chk("load_wren_ignored", 32'(bus.data_fromRAM), 32'hA5A5);
    bus.wrEn = 1'b0;
    tick();
    chk("load_7_kept", 32'(bus.data_fromRAM), 32'hA5A5);

    // ld_valid and ld_done on the same edge
    bus.ld_valid = 1'b1; bus.ld_done = 1'b1; bus.ld_addr = 13'd3; bus.ld_data = 16'h0F0F;
    bus.addr_toRAM = 13'd3;
    tick();
    bus.ld_valid = 1'b0; bus.ld_done = 1'b0;
    chk("sim_wf_ld_3",   32'(bus.data_fromRAM), 32'h0F0F);
    chk("sim_cpu_rst",   32'(bus.cpu_rst),      32'd0);
    chk("sim_ld_count",  32'(bus.ld_count),     32'd1);

    // ld_start together with a CPU write
    bus.ld_start = 1'b1; bus.wrEn = 1'b1; bus.addr_toRAM = 13'd9; bus.data_toRAM = 16'h1111;
    tick();
    bus.ld_start = 1'b0; bus.wrEn = 1'b0;
    chk("start_wr_9",       32'(bus.data_fromRAM), 32'h1111);
    chk("start_wr_cpu_rst", 32'(bus.cpu_rst),      32'd1);
    chk("start_wr_count",   32'(bus.ld_count),     32'd0);
    tick();
    chk("reread_9", 32'(bus.data_fromRAM), 32'h1111);

    // Out-of-range loader word still counts
    bus.ld_valid = 1'b1; bus.ld_addr = 13'd4096; bus.ld_data = 16'h7E7E; bus.addr_toRAM = 13'd4096;
    tick();
    bus.ld_valid = 1'b0;
    chk("ld_oor_count", 32'(bus.ld_count),     32'd1);
    chk("ld_oor_rdata", 32'(bus.data_fromRAM), 32'd0);
    bus.ld_done = 1'b1;
    tick();
    bus.ld_done = 1'b0;

    // Boundary: last implemented word and first out-of-range word
    bus.wrEn = 1'b1; bus.addr_toRAM = 13'd4095; bus.data_toRAM = 16'h7777;
    tick();
    chk("wr_4095", 32'(bus.data_fromRAM), 32'h7777);
    bus.addr_toRAM = 13'd4096; bus.data_toRAM = 16'hDEAD;
    tick();
    chk("wr_4096_wf", 32'(bus.data_fromRAM), 32'd0);
    bus.wrEn = 1'b0;
    tick();
    chk("rd_4096", 32'(bus.data_fromRAM), 32'd0);
    bus.addr_toRAM = 13'd4095;
    tick();
    chk("rd_4095", 32'(bus.data_fromRAM), 32'h7777);

    // Reset mid-RUN forces LOAD at once; contents survive
    rst = 1'b0;
    #2;
    chk("midrst_cpu_rst",  32'(bus.cpu_rst),      32'd1);
    chk("midrst_ld_ready", 32'(bus.ld_ready),     32'd1);
    chk("midrst_rdata",    32'(bus.data_fromRAM), 32'd0);
    rst = 1'b1;
    bus.addr_toRAM = 13'd0;
    tick();
    chk("retain_0",       32'(bus.data_fromRAM), 32'h1234);
    chk("retain_cpu_rst", 32'(bus.cpu_rst),      32'd1);

    bus.ld_done = 1'b1;
    tick();
    bus.ld_done = 1'b0;
    bus.wrEn = 1'b1; bus.addr_toRAM = 13'h1FFF; bus.data_toRAM = 16'h00FF;
    tick();
    bus.wrEn = 1'b0;
`ifdef MMIO_OUT_EN
    chk("mmio_io_out", 32'(bus.io_out),       32'h00FF);
    chk("mmio_wf",     32'(bus.data_fromRAM), 32'h00FF);
    tick();
    chk("mmio_read",   32'(bus.data_fromRAM), 32'h00FF);
`else
    chk("top_wf_oor",  32'(bus.data_fromRAM), 32'd0);
    tick();
    chk("top_rd_oor",  32'(bus.data_fromRAM), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
